decode_issue: RTL and testbench
===============================

DECODE_ISSUE -- requirements
Module: decode_issue

Interface
REQ-001 Parameter LOAD_USE_STALL, default 1, meaning 1 enables the load-use interlock and 0 disables it.
REQ-002 clk  input  1  Rising-edge clock; the block SHALL use this single clock only.
REQ-003 rst_n  input  1  Reset; the block SHALL treat it as asynchronous and active-low.
REQ-004 flush  input  1  Synchronous kill of the held instruction and any pending bubble.
REQ-005 in_valid / in_ready  input / output  1 / 1  Upstream instruction handshake.
REQ-006 in_instr, in_pc, rs1_data, rs2_data  input  32 each  Instruction word, its PC, and register-file read data.
REQ-007 rs1_addr, rs2_addr  output  5 each  Combinational in_instr[19:15] and in_instr[24:20], for register-file read.
REQ-008 out_valid / out_ready  output / input  1 / 1  Downstream execute handshake.
REQ-009 alu_a, alu_b  output  32 each  ALU operands.
REQ-010 opcode 7, func3 3, func7 1  output  ALU control fields.
REQ-011 imm, target, store_data  output  32 each  Immediate value, branch/jump target, and store data.
REQ-012 rd 5, reg_we 1, mem_rd 1, mem_wr 1, illegal 1  output  Writeback and memory controls, plus the illegal-instruction flag.

Function
REQ-013 All outputs other than in_ready and rs*_addr SHALL be registered in one output stage, giving a latency of 1 cycle from the in_valid&in_ready transfer to out_valid.
REQ-014 The load enable SHALL be ld = !out_valid | out_ready; while ld=0, every registered output SHALL hold stable.
REQ-015 in_ready SHALL equal ld & !stall & !flush.
REQ-016 The immediate SHALL use these types:
- I-type: jalr, loads, AI
- S-type: stores
- B-type: branches
- U-type: lui, auipc
- J-type: jal
- All immediates sign-extended to 32 bits; AR gives imm=0.
REQ-017 alu_a SHALL be selected as follows:
- in_pc for auipc, jal and jalr
- 0 for lui
- rs1_data otherwise
REQ-018 alu_b SHALL be selected as follows:
- rs2_data for AR and branches
- {27'b0, imm[4:0]} for AI with func3 001 or 101
- imm otherwise
REQ-019 func7 SHALL equal in_instr[30] for AR, and for AI with func3=101; otherwise it SHALL be 0.
REQ-020 target SHALL be in_pc+imm for branches and jal, (rs1_data+imm)&~1 for jalr, and 0 otherwise.
REQ-021 store_data SHALL be rs2_data.
REQ-022 reg_we SHALL be 1 for lui, auipc, jal, jalr, loads, AI and AR when rd≠0.
REQ-023 mem_rd SHALL be 1 for loads only, and mem_wr SHALL be 1 for stores only.
REQ-024 The instruction SHALL be flagged illegal for any of the following:
- opcode outside the nine supported values
- branch func3 010/011
- load func3 011/110/111
- store func3 >010
- AR funct7 other than 0000000, or 0100000 paired with func3 ∉{000,101}
- AI shift funct7 other than 0000000, or 0100000 paired with func3=001
REQ-025 An illegal instruction SHALL still transfer, with illegal=1, opcode=0, reg_we=mem_rd=mem_wr=0.
REQ-026 rs1 usage SHALL be every opcode except lui, auipc and jal; rs2 usage SHALL be AR, branches and stores.
REQ-027 With LOAD_USE_STALL=1, stall SHALL be 1 when all of the following hold:
- out_valid=1, mem_rd=1 and rd≠0
- in_valid=1
- a used rs1/rs2 field of in_instr equals rd
REQ-028 Under stall with ld=1, the output stage SHALL load a bubble (out_valid=0); the stall then clears and the instruction transfers the next cycle, giving exactly one bubble cycle.
REQ-029 Under stall with ld=0, the block SHALL wait with no change.
REQ-030 flush SHALL take priority over all else: out_valid=0 the next cycle, and no transfer in the flush cycle.
REQ-031 On a cycle with ld=1 and no transfer, out_valid SHALL become 0.

Reset
REQ-032 While rst_n=0, all registered outputs SHALL be 0, including out_valid=0 and illegal=0.
REQ-033 in_ready SHALL follow REQ-015 with out_valid=0, i.e. equal !flush.
REQ-034 Reset asserted mid-stall or mid-backpressure SHALL discard the held instruction, with no bubble pending afterwards.

Verification
REQ-035 addi x5,x1,-3 (0xFFD08293), rs1_data=10 -> next cycle: out_valid=1, alu_a=10, alu_b=0xFFFFFFFD, opcode=0010011, func3=0, rd=5, reg_we=1.
REQ-036 sub x3,x1,x2 (0x402081B3) -> opcode=0110011, func3=0, func7=1, alu_b=rs2_data, rd=3.
REQ-037 lw x6,0(x1) (0x0000A303), then add x7,x6,x0 (0x000303B3), out_ready=1 -> lw out, bubble with out_valid=0, then add out; in_ready=0 for exactly one cycle. With LOAD_USE_STALL=0 -> no bubble.
REQ-038 beq x1,x2,+8 (0x00208463) at pc=0x100 -> target=0x108, alu_b=rs2_data, reg_we=0.
REQ-039 Hold out_ready=0 for 3 cycles with out_valid=1 -> all outputs stable, in_ready=0. Then issue 0xFFFFFFFF -> illegal=1, opcode=0, reg_we=0.
REQ-040 flush with out_valid=1 and in_valid=1 -> next cycle out_valid=0, in_ready=0 during the flush cycle. Separately, rst_n low during a stall -> all outputs 0 and no bubble afterwards.

Source files
------------

// File: rtl/decode_issue.sv
// decode_issue: RV32I decode/issue stage with one registered output slot.
// Ports: upstream instr handshake, regfile read, downstream ALU bundle.
module decode_issue #(
  parameter bit LOAD_USE_STALL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [6:0]  opcode,
  output logic [2:0]  func3,
  output logic        func7,
  output logic [31:0] imm,
  output logic [31:0] target,
  output logic [31:0] store_data,
  output logic [4:0]  rd,
  output logic        reg_we,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        illegal
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_AI    = 7'b0010011;
  localparam logic [6:0] OP_AR    = 7'b0110011;

  localparam logic [6:0] F7_0   = 7'b0000000;
  localparam logic [6:0] F7_ALT = 7'b0100000;

  typedef struct packed {
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] imm;
    logic [31:0] target;
    logic [31:0] store_data;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic        func7;
    logic [4:0]  rd;
    logic        reg_we;
    logic        mem_rd;
    logic        mem_wr;
    logic        illegal;
  } id_ex_t;

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;

  assign op = in_instr[6:0];
  assign f3 = in_instr[14:12];
  assign f7 = in_instr[31:25];

  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];

  logic is_lui, is_auipc, is_jal, is_jalr;
  logic is_br, is_ld, is_st, is_ai, is_ar;
  logic is_shift;

  assign is_lui   = (op == OP_LUI);
  assign is_auipc = (op == OP_AUIPC);
  assign is_jal   = (op == OP_JAL);
  assign is_jalr  = (op == OP_JALR);
  assign is_br    = (op == OP_BR);
  assign is_ld    = (op == OP_LD);
  assign is_st    = (op == OP_ST);
  assign is_ai    = (op == OP_AI);
  assign is_ar    = (op == OP_AR);

  // Shift-immediate forms carry funct7 in the imm field.
  assign is_shift = is_ai &
    ((f3 == 3'b001) | (f3 == 3'b101));

  logic [31:0] imm_i, imm_s, imm_b;
  logic [31:0] imm_u, imm_j;

  assign imm_i = {{20{in_instr[31]}},
                  in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}},
                  in_instr[31:25],
                  in_instr[11:7]};
  assign imm_b = {{19{in_instr[31]}},
                  in_instr[31],
                  in_instr[7],
                  in_instr[30:25],
                  in_instr[11:8],
                  1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};
  assign imm_j = {{11{in_instr[31]}},
                  in_instr[31],
                  in_instr[19:12],
                  in_instr[20],
                  in_instr[30:21],
                  1'b0};

  logic [31:0] imm_sel;

  always_comb begin
    imm_sel = '0;
    unique case (1'b1)
      is_jalr, is_ld, is_ai: imm_sel = imm_i;
      is_st:                 imm_sel = imm_s;
      is_br:                 imm_sel = imm_b;
      is_lui, is_auipc:      imm_sel = imm_u;
      is_jal:                imm_sel = imm_j;
      default:               imm_sel = '0;
    endcase
  end

  logic bad;

  always_comb begin
    bad = 1'b0;
    unique case (1'b1)
      is_br:
        bad = (f3 == 3'b010) | (f3 == 3'b011);
      is_ld:
        bad = (f3 == 3'b011) | (f3[2:1] == 2'b11);
      is_st:
        bad = (f3 > 3'b010);
      is_ar:
        bad = !((f7 == F7_0) |
                ((f7 == F7_ALT) &
                 ((f3 == 3'b000) | (f3 == 3'b101))));
      is_ai:
        bad = is_shift &
              !((f7 == F7_0) |
                ((f7 == F7_ALT) & (f3 == 3'b101)));
      is_lui, is_auipc, is_jal, is_jalr:
        bad = 1'b0;
      default:
        bad = 1'b1;
    endcase
  end

  logic [31:0] op_a, op_b;

  always_comb begin
    op_a = rs1_data;
    unique case (1'b1)
      is_auipc, is_jal, is_jalr: op_a = in_pc;
      is_lui:                    op_a = '0;
      default:                   op_a = rs1_data;
    endcase
  end

  always_comb begin
    op_b = imm_sel;
    unique case (1'b1)
      is_ar, is_br: op_b = rs2_data;
      is_shift:     op_b = {27'b0, imm_sel[4:0]};
      default:      op_b = imm_sel;
    endcase
  end

  logic [31:0] pc_sum, jr_sum, tgt;

  assign pc_sum = in_pc + imm_sel;
  assign jr_sum = rs1_data + imm_sel;

  always_comb begin
    tgt = '0;
    unique case (1'b1)
      is_br, is_jal: tgt = pc_sum;
      is_jalr:       tgt = {jr_sum[31:1], 1'b0};
      default:       tgt = '0;
    endcase
  end

  logic wb_op;

  assign wb_op = is_lui | is_auipc | is_jal |
                 is_jalr | is_ld | is_ai | is_ar;

  id_ex_t dec;

  always_comb begin
    dec            = '0;
    dec.alu_a      = op_a;
    dec.alu_b      = op_b;
    dec.imm        = imm_sel;
    dec.target     = tgt;
    dec.store_data = rs2_data;
    dec.opcode     = bad ? 7'd0 : op;
    dec.func3      = f3;
    dec.func7      = (is_ar | (is_ai & (f3 == 3'b101)))
                     & in_instr[30];
    dec.rd         = in_instr[11:7];
    dec.reg_we     = !bad & wb_op &
                     (in_instr[11:7] != 5'd0);
    dec.mem_rd     = !bad & is_ld;
    dec.mem_wr     = !bad & is_st;
    dec.illegal    = bad;
  end

  id_ex_t ex_d, ex_q;
  logic   valid_d, valid_q;

  logic use_rs1, use_rs2;
  logic hazard, stall, ld, xfer;

  assign use_rs1 = !(is_lui | is_auipc | is_jal);
  assign use_rs2 = is_ar | is_br | is_st;

  // Load in the slot whose result the incoming
  // instruction needs: hold it back one cycle.
  assign hazard = valid_q & ex_q.mem_rd &
                  (ex_q.rd != 5'd0) & in_valid &
                  ((use_rs1 & (rs1_addr == ex_q.rd)) |
                   (use_rs2 & (rs2_addr == ex_q.rd)));

  assign stall    = LOAD_USE_STALL & hazard;
  assign ld       = !valid_q | out_ready;
  assign in_ready = ld & !stall & !flush;
  assign xfer     = in_valid & in_ready;

  // A load cycle without a transfer empties the
  // slot; this is what produces the stall bubble.
  always_comb begin
    valid_d = valid_q;
    ex_d    = ex_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (ld) begin
      valid_d = xfer;
      if (xfer) ex_d = dec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ex_q    <= '0;
    end else begin
      valid_q <= valid_d;
      ex_q    <= ex_d;
    end
  end

  assign out_valid  = valid_q;
  assign alu_a      = ex_q.alu_a;
  assign alu_b      = ex_q.alu_b;
  assign opcode     = ex_q.opcode;
  assign func3      = ex_q.func3;
  assign func7      = ex_q.func7;
  assign imm        = ex_q.imm;
  assign target     = ex_q.target;
  assign store_data = ex_q.store_data;
  assign rd         = ex_q.rd;
  assign reg_we     = ex_q.reg_we;
  assign mem_rd     = ex_q.mem_rd;
  assign mem_wr     = ex_q.mem_wr;
  assign illegal    = ex_q.illegal;

endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue: directed + randomized bench for decode_issue
// against a behavioural decode/issue reference model.
module tb_decode_issue;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc, rs1_data, rs2_data;

  logic        in_ready, out_valid, func7;
  logic [4:0]  rs1_addr, rs2_addr, rd;
  logic [31:0] alu_a, alu_b, imm, target, store_data;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic        reg_we, mem_rd, mem_wr, illegal;

  logic        in_ready0, out_valid0, func7_0;
  logic [4:0]  rs1_addr0, rs2_addr0, rd0;
  logic [31:0] alu_a0, alu_b0, imm0, target0, store_data0;
  logic [6:0]  opcode0;
  logic [2:0]  func3_0;
  logic        reg_we0, mem_rd0, mem_wr0, illegal0;

  always #5 clk = ~clk;

  decode_issue u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b),
    .opcode(opcode), .func3(func3), .func7(func7),
    .imm(imm), .target(target),
    .store_data(store_data), .rd(rd),
    .reg_we(reg_we), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .illegal(illegal)
  );

  decode_issue #(.LOAD_USE_STALL(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0),
    .in_instr(in_instr), .in_pc(in_pc),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_addr(rs1_addr0), .rs2_addr(rs2_addr0),
    .out_valid(out_valid0), .out_ready(out_ready),
    .alu_a(alu_a0), .alu_b(alu_b0),
    .opcode(opcode0), .func3(func3_0), .func7(func7_0),
    .imm(imm0), .target(target0),
    .store_data(store_data0), .rd(rd0),
    .reg_we(reg_we0), .mem_rd(mem_rd0),
    .mem_wr(mem_wr0), .illegal(illegal0)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] a, b, imm, tgt, sd;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rd;
    logic        we, mr, mw, ill, u1, u2;
  } exp_t;

  function automatic exp_t ref_dec(input logic [31:0] i,
                                   input logic [31:0] pc,
                                   input logic [31:0] r1,
                                   input logic [31:0] r2);
    exp_t e;
    int s20, s25, s31;
    logic [6:0] f7;
    logic [2:0] f3;
    bit wb, shift;
    f3  = i[14:12];
    f7  = i[31:25];
    s20 = $signed(i) >>> 20;
    s25 = $signed(i) >>> 25;
    s31 = $signed(i) >>> 31;
    e = '0;
    wb = 0;
    e.a  = r1;
    e.sd = r2;
    e.rd = i[11:7];
    e.f3 = f3;
    e.u1 = 1;
    shift = (f3 == 3'd1) || (f3 == 3'd5);
    case (i[6:0])
      7'h37: begin
        e.imm = i & 32'hFFFFF000;
        e.a = 0; e.b = e.imm; e.u1 = 0; wb = 1;
      end
      7'h17: begin
        e.imm = i & 32'hFFFFF000;
        e.a = pc; e.b = e.imm; e.u1 = 0; wb = 1;
      end
      7'h6F: begin
        e.imm = 32'(s31 * 1048576 +
                    int'(i[19:12]) * 4096 +
                    int'(i[20]) * 2048 +
                    int'(i[30:21]) * 2);
        e.a = pc; e.b = e.imm; e.tgt = pc + e.imm;
        e.u1 = 0; wb = 1;
      end
      7'h67: begin
        e.imm = 32'(s20);
        e.a = pc; e.b = e.imm;
        e.tgt = (r1 + e.imm) & 32'hFFFFFFFE;
        wb = 1;
      end
      7'h63: begin
        e.imm = 32'(s31 * 4096 +
                    int'(i[7]) * 2048 +
                    int'(i[30:25]) * 32 +
                    int'(i[11:8]) * 2);
        e.b = r2; e.tgt = pc + e.imm; e.u2 = 1;
        e.ill = (f3 == 3'd2) || (f3 == 3'd3);
      end
      7'h03: begin
        e.imm = 32'(s20);
        e.b = e.imm; e.mr = 1; wb = 1;
        e.ill = (f3 == 3'd3) || (f3 >= 3'd6);
      end
      7'h23: begin
        e.imm = 32'(s25 * 32 + int'(i[11:7]));
        e.b = e.imm; e.mw = 1; e.u2 = 1;
        e.ill = (f3 > 3'd2);
      end
      7'h13: begin
        e.imm = 32'(s20);
        e.b = shift ? e.imm % 32 : e.imm;
        e.f7 = (f3 == 3'd5) ? i[30] : 1'b0;
        wb = 1;
        e.ill = shift && !(f7 == 7'd0 ||
                (f7 == 7'h20 && f3 == 3'd5));
      end
      7'h33: begin
        e.imm = 0;
        e.b = r2; e.f7 = i[30]; e.u2 = 1; wb = 1;
        e.ill = !(f7 == 7'd0 || (f7 == 7'h20 &&
                  (f3 == 3'd0 || f3 == 3'd5)));
      end
      default: begin
        e.ill = 1;
        e.b = 0;
      end
    endcase
    if (e.ill) begin
      e.op = 0; e.we = 0; e.mr = 0; e.mw = 0;
    end else begin
      e.op = i[6:0];
      e.we = wb && (e.rd != 0);
    end
    return e;
  endfunction

  task automatic drive(input logic v,
                       input logic [31:0] i,
                       input logic [31:0] pc,
                       input logic [31:0] a,
                       input logic [31:0] b);
    in_valid = v; in_instr = i; in_pc = pc;
    rs1_data = a; rs2_data = b;
  endtask

  localparam logic [31:0] ADDI = 32'hFFD08293;
  localparam logic [31:0] SUB  = 32'h402081B3;
  localparam logic [31:0] BEQ  = 32'h00208463;
  localparam logic [31:0] LW   = 32'h0000A303;
  localparam logic [31:0] ADD  = 32'h000303B3;

  logic [6:0] ops [9] = '{7'h37, 7'h17, 7'h6F,
                          7'h67, 7'h63, 7'h03,
                          7'h23, 7'h13, 7'h33};

  exp_t m, e;
  logic m_valid, ld, stall, rdy;
  logic [6:0] rop, rf7;
  int k;

  initial begin
    rst_n = 0; flush = 0; out_ready = 1;
    drive(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_illegal", illegal, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_imm", imm, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1;

    drive(1, ADDI, 0, 10, 32'h55);
    #1;
    check("addi_rs1_addr", rs1_addr, 1);
    check("addi_rs2_addr", rs2_addr, 29);
    @(negedge clk);
    check("addi_valid", out_valid, 1);
    check("addi_alu_a", alu_a, 10);
    check("addi_alu_b", alu_b, 32'hFFFFFFFD);
    check("addi_opcode", opcode, 7'h13);
    check("addi_func3", func3, 0);
    check("addi_rd", rd, 5);
    check("addi_reg_we", reg_we, 1);

    drive(1, SUB, 4, 10, 32'h1234);
    @(negedge clk);
    check("sub_opcode", opcode, 7'h33);
    check("sub_func3", func3, 0);
    check("sub_func7", func7, 1);
    check("sub_alu_b", alu_b, 32'h1234);
    check("sub_rd", rd, 3);

    drive(1, BEQ, 32'h100, 7, 9);
    @(negedge clk);
    check("beq_target", target, 32'h108);
    check("beq_alu_b", alu_b, 9);
    check("beq_reg_we", reg_we, 0);

    drive(1, LW, 32'h200, 32'h1000, 0);
    @(negedge clk);
    check("lw_valid", out_valid, 1);
    check("lw_mem_rd", mem_rd, 1);
    check("lw_rd", rd, 6);
    drive(1, ADD, 32'h204, 5, 6);
    #1;
    check("lu_in_ready", in_ready, 0);
    check("lu_in_ready_nostall", in_ready0, 1);
    @(negedge clk);
    check("lu_bubble", out_valid, 0);
    check("nostall_valid", out_valid0, 1);
    check("nostall_rd", rd0, 7);
    #1;
    check("lu_in_ready_after", in_ready, 1);
    @(negedge clk);
    check("add_valid", out_valid, 1);
    check("add_rd", rd, 7);
    check("add_opcode", opcode, 7'h33);

    drive(1, ADDI, 0, 10, 0);
    @(negedge clk);
    out_ready = 0;
    drive(1, 32'hFFFFFFFF, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp_in_ready", in_ready, 0);
      @(negedge clk);
      rs1_data = $urandom;
      check("bp_valid", out_valid, 1);
      check("bp_alu_a", alu_a, 10);
      check("bp_alu_b", alu_b, 32'hFFFFFFFD);
      check("bp_rd", rd, 5);
    end
    out_ready = 1;
    #1;
    check("ill_in_ready", in_ready, 1);
    @(negedge clk);
    check("ill_valid", out_valid, 1);
    check("ill_flag", illegal, 1);
    check("ill_opcode", opcode, 0);
    check("ill_reg_we", reg_we, 0);

    drive(1, ADDI, 0, 10, 0);
    flush = 1;
    #1;
    check("flush_in_ready", in_ready, 0);
    @(negedge clk);
    flush = 0;
    check("flush_valid", out_valid, 0);

    drive(1, LW, 0, 32'h1000, 0);
    @(negedge clk);
    check("rlw_mem_rd", mem_rd, 1);
    drive(1, ADD, 0, 5, 6);
    #1;
    check("rst_stall_ready", in_ready, 0);
    #2;
    rst_n = 0;
    #1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_mem_rd", mem_rd, 0);
    check("rst_mid_rd", rd, 0);
    check("rst_mid_alu_a", alu_a, 0);
    check("rst_mid_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1;
    #1;
    check("rst_no_bubble", in_ready, 1);
    @(negedge clk);
    check("rst_add_valid", out_valid, 1);
    check("rst_add_rd", rd, 7);
    in_valid = 0;
    @(posedge clk);
    m_valid = 0;
    m = '0;

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      check("r_out_valid", out_valid, m_valid);
      if (m_valid) begin
        check("r_illegal", illegal, m.ill);
        check("r_opcode", opcode, m.op);
        check("r_reg_we", reg_we, m.we);
        check("r_mem_rd", mem_rd, m.mr);
        check("r_mem_wr", mem_wr, m.mw);
        check("r_rd", rd, m.rd);
        if (!m.ill) begin
          check("r_alu_a", alu_a, m.a);
          check("r_alu_b", alu_b, m.b);
          check("r_imm", imm, m.imm);
          check("r_target", target, m.tgt);
          check("r_store", store_data, m.sd);
          check("r_func3", func3, m.f3);
          check("r_func7", func7, m.f7);
        end
      end
      k = $urandom_range(0, 9);
      rop = (k < 9) ? ops[k] : 7'($urandom);
      k = $urandom_range(0, 3);
      rf7 = (k == 1) ? 7'h20 :
            (k == 3) ? 7'($urandom) : 7'h00;
      in_instr = {rf7,
                  5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)),
                  3'($urandom),
                  5'($urandom_range(0, 3)),
                  rop};
      in_pc     = $urandom;
      rs1_data  = $urandom;
      rs2_data  = $urandom;
      in_valid  = ($urandom_range(0, 4) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      #1;
      e = ref_dec(in_instr, in_pc, rs1_data, rs2_data);
      ld = !m_valid || out_ready;
      stall = m_valid && m.mr && (m.rd != 0) &&
              in_valid &&
              ((e.u1 && in_instr[19:15] == m.rd) ||
               (e.u2 && in_instr[24:20] == m.rd));
      rdy = ld && !stall && !flush;
      check("r_in_ready", in_ready, rdy);
      check("r_rs1_addr", rs1_addr, in_instr[19:15]);
      @(posedge clk);
      if (flush) begin
        m_valid = 0;
      end else if (ld) begin
        if (in_valid && rdy) begin
          m_valid = 1;
          m = e;
        end else begin
          m_valid = 0;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
